i2c_req_arbiter: RTL and testbench
==================================

Name: i2c_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one i2c_master between NUM_REQ requesters. It latches a winning request and drives the master's addr/rw/data_w/start. It tracks the master's busy/valid_out/erro_addr and returns read data plus a status pulse to the granted requester. Sits between client blocks (sensor pollers, config loaders) and the single i2c_master instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_CYC, 2, clk cycles m_start is held high per launch
TIMEOUT_CYC, 4096, max cycles from launch to m_busy falling before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request level
req_addr  in  7*NUM_REQ  7-bit slave address, requester i at [7i+6:7i]
req_rw  in  NUM_REQ  1=read, 0=write
req_wdata  in  8*NUM_REQ  write byte, requester i at [8i+7:8i]
gnt  out  NUM_REQ  one-hot grant, high from selection through done
done  out  NUM_REQ  one-cycle completion pulse to granted requester
rsp_rdata  out  8  read byte, valid with done
rsp_err  out  1  1=address NACK or timeout, valid with done
rsp_timeout  out  1  1=timeout abort, valid with done
m_addr  out  7  to i2c_master addr
m_rw  out  1  to i2c_master rw
m_data_w  out  8  to i2c_master data_w
m_start  out  1  to i2c_master start
m_data_out  in  8  from i2c_master data_out
m_valid_out  in  1  from i2c_master valid_out
m_busy  in  1  from i2c_master busy
m_erro_addr  in  1  from i2c_master erro_addr

Behaviour:
- Reset (async, rst_n=0): state IDLE, rr pointer=0, all outputs 0, error/timeout flags cleared. Reset mid-transaction drops m_start immediately; no done is issued.
- States: IDLE -> LAUNCH -> WAIT_BUSY -> RUN -> DONE -> IDLE.
- IDLE: if any req, select the first set bit at or after rr pointer (wrapping). Latch its addr/rw/wdata into m_addr/m_rw/m_data_w, set gnt[i], go LAUNCH next cycle. No req: stay.
- LAUNCH: m_start=1 for exactly START_CYC cycles, then WAIT_BUSY. Timeout counter starts at the first LAUNCH cycle.
- WAIT_BUSY: on m_busy=1 go RUN.
- RUN: on m_valid_out=1 capture m_data_out into rsp_rdata; last capture wins. If m_erro_addr=1 while in WAIT_BUSY or RUN, set a sticky error. On m_busy falling to 0 go DONE.
- Timeout: if the counter reaches TIMEOUT_CYC in LAUNCH, WAIT_BUSY or RUN, set rsp_err=1 and rsp_timeout=1, then go DONE. m_start is forced 0.
- DONE: one cycle. done[i]=1, rsp_err=sticky error or timeout. gnt[i] drops the following cycle. rr pointer=i+1 mod NUM_REQ. Return to IDLE.
- Write transactions leave rsp_rdata unchanged. m_addr/m_rw/m_data_w are stable from LAUNCH through DONE.
- Requester contract: hold req and fields until done. Deasserting req mid-transaction is ignored and the transaction completes. A req still high after done is re-arbitrated as a new request.
- New requests arriving during a transaction wait. At most one transaction is in flight. The minimum gap between back-to-back transactions is 1 IDLE cycle.
- Counter width: $clog2(TIMEOUT_CYC+1) bits; saturates, never wraps.

Optional Feature:
Macro I2C_ARB_RETRY_EN.
- Defined: adds parameter MAX_RETRY (default 2). On address NACK at busy fall, relaunch the same latched command (back to LAUNCH) up to MAX_RETRY times, with the timeout counter reset per attempt. rsp_err=1 only if the final attempt NACKs. gnt stays high across retries.
- Not defined: single attempt; NACK reported directly.

Test Plan:
- Single write: req[0], addr=7'b1011001, rw=0, wdata=8'hA5. Response: m_start high 2 cycles; m_addr/m_data_w match; done[0] 1 cycle after busy falls; rsp_err=0.
- Read: req[2], rw=1, model returns valid_out with 8'h5A. Response: done[2] with rsp_rdata=8'h5A, rsp_err=0.
- Contention: req=4'b1111 held. Response: grant order 0,1,2,3,0; exactly one gnt bit at a time; each done precedes the next m_start.
- NACK: model pulses erro_addr during the address phase. Without the macro: done with rsp_err=1. With the macro, MAX_RETRY=2 and NACK twice then ACK: 3 m_start bursts, rsp_err=0.
- Timeout: model never raises busy, TIMEOUT_CYC=64. Response: done at cycle 64 after launch, rsp_err=1, rsp_timeout=1.
- Reset mid-RUN: rst_n low during busy. Response: all outputs 0 immediately, no done. After release, a pending req[1] is granted first (pointer=0 scan).

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_master among NUM_REQ requesters.
// Define I2C_ARB_RETRY_EN to relaunch address-NACKed commands up to MAX_RETRY times.
module i2c_req_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned START_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
`ifdef I2C_ARB_RETRY_EN
  ,
  parameter int unsigned MAX_RETRY   = 2
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [6:0]           m_addr,
  output logic                 m_rw,
  output logic [7:0]           m_data_w,
  output logic                 m_start,
  input  logic [7:0]           m_data_out,
  input  logic                 m_valid_out,
  input  logic                 m_busy,
  input  logic                 m_erro_addr
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
`ifdef I2C_ARB_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`endif

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] rr;
  logic [IW-1:0] gnt_idx;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic          err;
`ifdef I2C_ARB_RETRY_EN
  logic [RW-1:0] retry_cnt;
`endif

  logic [IW-1:0]      sel_idx;
  logic               sel_vld;
  logic [NUM_REQ-1:0] sel_oh;
  logic [6:0]         sel_addr;
  logic               sel_rw;
  logic [7:0]         sel_wdata;
  int unsigned        cand;
  logic [TW-1:0]      tcnt_sat;
  logic               timeout_hit;

  // First requester at or after the rr pointer, wrapping
  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr) + k) % NUM_REQ;
      if (!sel_vld && req[IW'(cand)]) begin
        sel_vld = 1'b1;
        sel_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    sel_oh    = '0;
    sel_addr  = '0;
    sel_rw    = 1'b0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == sel_idx) begin
        sel_oh[i] = sel_vld;
        sel_addr  = req_addr[7*i +: 7];
        sel_rw    = req_rw[i];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  // Saturating launch-to-completion watchdog
  assign tcnt_sat    = (tcnt == TW'(TIMEOUT_CYC)) ? tcnt : tcnt + TW'(1);
  assign timeout_hit = (tcnt_sat == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr          <= '0;
      gnt_idx     <= '0;
      scnt        <= '0;
      tcnt        <= '0;
      err         <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      m_addr      <= '0;
      m_rw        <= 1'b0;
      m_data_w    <= '0;
      m_start     <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
      retry_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            m_addr   <= sel_addr;
            m_rw     <= sel_rw;
            m_data_w <= sel_wdata;
            gnt      <= sel_oh;
            gnt_idx  <= sel_idx;
            m_start  <= 1'b1;
            scnt     <= '0;
            tcnt     <= '0;
            err      <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
            retry_cnt <= '0;
`endif
            state    <= LAUNCH;
          end
        end
        LAUNCH, WAIT_BUSY, RUN: begin
          tcnt <= tcnt_sat;
          if (timeout_hit) begin
            m_start     <= 1'b0;
            done        <= gnt;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= DONE;
          end else begin
            if (state != LAUNCH && m_erro_addr) err <= 1'b1;
            if (state == LAUNCH) begin
              if (scnt == SW'(START_CYC - 1)) begin
                m_start <= 1'b0;
                state   <= WAIT_BUSY;
              end else begin
                scnt <= scnt + SW'(1);
              end
            end else if (state == WAIT_BUSY) begin
              if (m_busy) state <= RUN;
            end else begin
              if (m_valid_out && m_rw) rsp_rdata <= m_data_out;
              if (!m_busy) begin
`ifdef I2C_ARB_RETRY_EN
                // Relaunch the latched command while retries remain
                if ((err || m_erro_addr) && retry_cnt != RW'(MAX_RETRY)) begin
                  retry_cnt <= retry_cnt + RW'(1);
                  err       <= 1'b0;
                  scnt      <= '0;
                  tcnt      <= '0;
                  m_start   <= 1'b1;
                  state     <= LAUNCH;
                end else begin
                  done    <= gnt;
                  rsp_err <= err || m_erro_addr;
                  state   <= DONE;
                end
`else
                done    <= gnt;
                rsp_err <= err || m_erro_addr;
                state   <= DONE;
`endif
              end
            end
          end
        end
        DONE: begin
          done        <= '0;
          gnt         <= '0;
          rsp_err     <= 1'b0;
          rsp_timeout <= 1'b0;
          rr          <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed self-checking bench for i2c_req_arbiter with a small behavioural i2c_master.
`timescale 1ns/1ps
module tb_i2c_req_arbiter;

  localparam int unsigned NR = 4;
`ifdef I2C_ARB_RETRY_EN
  localparam int NACK_BURSTS = 3;
`else
  localparam int NACK_BURSTS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [7*NR-1:0] req_addr;
  logic [NR-1:0] req_rw;
  logic [8*NR-1:0] req_wdata;
  logic [NR-1:0] gnt, done;
  logic [7:0]    rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [6:0]    m_addr;
  logic          m_rw;
  logic [7:0]    m_data_w;
  logic          m_start;
  logic [7:0]    m_data_out;
  logic          m_valid_out, m_busy, m_erro_addr;

  i2c_req_arbiter #(.NUM_REQ(NR), .START_CYC(2), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .m_addr(m_addr), .m_rw(m_rw),
    .m_data_w(m_data_w), .m_start(m_start), .m_data_out(m_data_out),
    .m_valid_out(m_valid_out), .m_busy(m_busy), .m_erro_addr(m_erro_addr)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Behavioural master; drives 2ns after the edge so the bench samples at +1ns race-free
  logic       mdl_nack = 1'b0, mdl_read = 1'b0, mdl_dead = 1'b0;
  logic [7:0] mdl_rdata = 8'h00;
  initial begin
    m_busy = 1'b0; m_valid_out = 1'b0; m_erro_addr = 1'b0; m_data_out = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (m_start && !mdl_dead) begin
        for (int n = 0; n < 50 && m_start; n++) begin @(posedge clk); #2; end
        m_busy = 1'b1;
        m_erro_addr = mdl_nack;
        @(posedge clk); #2; m_erro_addr = 1'b0;
        @(posedge clk); #2;
        if (mdl_read) begin m_valid_out = 1'b1; m_data_out = mdl_rdata; end
        @(posedge clk); #2; m_valid_out = 1'b0;
        @(posedge clk); #2; m_busy = 1'b0;
      end
    end
  end

  int bursts = 0, cur_len = 0, last_len = 0, done_cnt = 0, onehot_bad = 0, overlap = 0;
  always @(negedge clk) begin
    if (m_start) cur_len++;
    else if (cur_len != 0) begin last_len = cur_len; bursts++; cur_len = 0; end
    if ($countones(gnt) > 1) onehot_bad++;
    if ((|done) && m_start) overlap++;
    if (|done) done_cnt++;
  end

  task automatic wait_done(input string tag, input int bound, output int n, output logic busy_prev);
    logic seen;
    seen = 1'b0;
    n = 0;
    busy_prev = m_busy;
    while (!seen && n < bound) begin
      busy_prev = m_busy;
      @(posedge clk); #1;
      n++;
      if (|done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b0, d0;
    logic bp;
    logic [NR-1:0] exp_order [5];
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

    rst_n = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_start", 32'(m_start), 32'h0);
    chk("rst_addr", 32'(m_addr), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: all four held, pointer starts at 0
    for (int i = 0; i < 4; i++) begin
      req_addr[7*i +: 7] = 7'(8'h10 + i);
      req_wdata[8*i +: 8] = 8'(8'hC0 + i);
    end
    b0 = bursts;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done("cont", 40, n, bp);
      chk("cont_done", 32'(done), 32'(exp_order[k]));
      chk("cont_gnt", 32'(gnt), 32'(exp_order[k]));
      chk("cont_len", 32'(last_len), 32'd2);
      if (k == 4) req = '0;
    end
    chk("cont_bursts", 32'(bursts - b0), 32'd5);

    // Single write on requester 0
    req_addr[6:0] = 7'b1011001; req_wdata[7:0] = 8'hA5; req_rw[0] = 1'b0;
    @(posedge clk); #1;
    req[0] = 1'b1;
    @(posedge clk); #1;
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_start0", 32'(m_start), 32'h1);
    chk("wr_addr", 32'(m_addr), 32'h59);
    chk("wr_data", 32'(m_data_w), 32'hA5);
    chk("wr_rw", 32'(m_rw), 32'h0);
    @(posedge clk); #1;
    chk("wr_start1", 32'(m_start), 32'h1);
    @(posedge clk); #1;
    chk("wr_start2", 32'(m_start), 32'h0);
    wait_done("wr", 40, n, bp);
    chk("wr_done", 32'(done), 32'h1);
    chk("wr_busy_prev", 32'(bp), 32'h1);
    chk("wr_busy_now", 32'(m_busy), 32'h0);
    chk("wr_rsp_err", 32'(rsp_err), 32'h0);
    chk("wr_addr_hold", 32'(m_addr), 32'h59);
    req = '0;
    @(posedge clk); #1;
    chk("wr_gnt_drop", 32'(gnt), 32'h0);
    chk("wr_done_drop", 32'(done), 32'h0);

    // Read on requester 2
    req_addr[20:14] = 7'h48; req_rw[2] = 1'b1; mdl_read = 1'b1; mdl_rdata = 8'h5A;
    req[2] = 1'b1;
    wait_done("rd", 40, n, bp);
    chk("rd_done", 32'(done), 32'h4);
    chk("rd_data", 32'(rsp_rdata), 32'h5A);
    chk("rd_err", 32'(rsp_err), 32'h0);
    chk("rd_rw", 32'(m_rw), 32'h1);
    chk("rd_addr", 32'(m_addr), 32'h48);
    req = '0; mdl_read = 1'b0;
    @(posedge clk); #1;

    // Address NACK on requester 3 (write keeps rsp_rdata)
    mdl_nack = 1'b1; b0 = bursts;
    req[3] = 1'b1;
    wait_done("nack", 80, n, bp);
    chk("nack_done", 32'(done), 32'h8);
    chk("nack_err", 32'(rsp_err), 32'h1);
    chk("nack_tmo", 32'(rsp_timeout), 32'h0);
    chk("nack_rdata", 32'(rsp_rdata), 32'h5A);
    chk("nack_bursts", 32'(bursts - b0), 32'(NACK_BURSTS));
    req = '0; mdl_nack = 1'b0;
    @(posedge clk); #1;

    // Timeout on requester 1: master never goes busy
    mdl_dead = 1'b1;
    req[1] = 1'b1;
    @(posedge clk); #1;
    chk("tmo_gnt", 32'(gnt), 32'h2);
    chk("tmo_start", 32'(m_start), 32'h1);
    wait_done("tmo", 100, n, bp);
    chk("tmo_cycles", 32'(n), 32'd64);
    chk("tmo_done", 32'(done), 32'h2);
    chk("tmo_err", 32'(rsp_err), 32'h1);
    chk("tmo_flag", 32'(rsp_timeout), 32'h1);
    chk("tmo_start_low", 32'(m_start), 32'h0);
    req = '0;
    @(posedge clk); #1;
    mdl_dead = 1'b0;
    chk("tmo_err_clr", 32'(rsp_err), 32'h0);
    chk("tmo_flag_clr", 32'(rsp_timeout), 32'h0);

    // Reset mid-RUN on requester 3, then requester 1 wins from pointer 0
    req_addr[27:21] = 7'h33; req_rw[3] = 1'b0;
    req[3] = 1'b1;
    n = 0;
    while (!m_busy && n < 20) begin @(posedge clk); #1; n++; end
    chk("rrst_busy_seen", 32'(m_busy), 32'h1);
    d0 = done_cnt;
    rst_n = 1'b0;
    req = 4'b1010;
    #1;
    chk("rrst_gnt", 32'(gnt), 32'h0);
    chk("rrst_start", 32'(m_start), 32'h0);
    chk("rrst_addr", 32'(m_addr), 32'h0);
    chk("rrst_wdata", 32'(m_data_w), 32'h0);
    chk("rrst_rdata", 32'(rsp_rdata), 32'h0);
    chk("rrst_done", 32'(done), 32'h0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rrst_gnt1", 32'(gnt), 32'h2);
    chk("rrst_start1", 32'(m_start), 32'h1);
    wait_done("rrst", 40, n, bp);
    chk("rrst_done1", 32'(done), 32'h2);
    req = '0;
    repeat (3) @(posedge clk);
    #1;

    chk("onehot", 32'(onehot_bad), 32'd0);
    chk("done_before_start", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
